// File: rtl/ins_class_pkg.sv
// rtl/ins_class_pkg.sv - opcodes, class bit indices and field positions for the class pipe
package ins_class_pkg;
  localparam int INS_W = 32;
  localparam int CLS_W = 8;

  localparam logic [4:0] OP_ALU  = 5'b00000;
  localparam logic [4:0] OP_J    = 5'b00001;
  localparam logic [4:0] OP_BNE  = 5'b00010;
  localparam logic [4:0] OP_JAL  = 5'b00011;
  localparam logic [4:0] OP_JR   = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_BLT  = 5'b00110;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_SETX = 5'b10101;
  localparam logic [4:0] OP_BEX  = 5'b10110;

  localparam int C_R   = 0;
  localparam int C_I   = 1;
  localparam int C_JI  = 2;
  localparam int C_JII = 3;
  localparam int C_LD  = 4;
  localparam int C_ST  = 5;
  localparam int C_BR  = 6;
  localparam int C_UNK = 7;

  localparam int RD_LSB = 22;
  localparam int RS_LSB = 17;
  localparam int RT_LSB = 12;

  // Source-select mask: which registers a stage-0 instruction reads.
  localparam int SRC_W = 4;
  localparam int S_RS  = 0;
  localparam int S_RT  = 1;
  localparam int S_RD  = 2;
  localparam int S_R30 = 3;
endpackage

// File: rtl/ins_class_pipe_if.sv
// rtl/ins_class_pipe_if.sv - instruction/control inputs and per-stage outputs of the class pipe
interface ins_class_pipe_if
  import ins_class_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int REGW  = 5,
  parameter int CNT_W = 32
);
  logic                     in_valid;
  logic [INS_W-1:0]         in_ins;
  logic                     stall;
  logic                     flush;
  logic [DEPTH-1:0]         stg_valid;
  logic [CLS_W*DEPTH-1:0]   stg_class;
  logic [REGW*DEPTH-1:0]    stg_rd;
  logic                     load_use;
  logic                     any_j_d;
  logic [CLS_W*CNT_W-1:0]   ret_cnt;

  modport master (
    output in_valid, in_ins, stall, flush,
    input  stg_valid, stg_class, stg_rd, load_use, any_j_d, ret_cnt
  );
  modport slave (
    input  in_valid, in_ins, stall, flush,
    output stg_valid, stg_class, stg_rd, load_use, any_j_d, ret_cnt
  );
endinterface

// File: rtl/ins_class_decode.sv
// rtl/ins_class_decode.sv - opcode to class vector and source-register select mask
module ins_class_decode
  import ins_class_pkg::*;
#(
  parameter int OPW = 5
) (
  input  logic [OPW-1:0]   opcode,
  output logic [CLS_W-1:0] cls,
  output logic [SRC_W-1:0] src
);
  always_comb begin
    cls = '0;
    src = '0;
    case (opcode)
      OPW'(OP_ALU):  cls[C_R] = 1'b1;
      OPW'(OP_ADDI): cls[C_I] = 1'b1;
      OPW'(OP_SW):   begin cls[C_I] = 1'b1; cls[C_ST] = 1'b1; end
      OPW'(OP_LW):   begin cls[C_I] = 1'b1; cls[C_LD] = 1'b1; end
      OPW'(OP_BNE),
      OPW'(OP_BLT):  begin cls[C_I] = 1'b1; cls[C_BR] = 1'b1; end
      OPW'(OP_J),
      OPW'(OP_JAL),
      OPW'(OP_SETX): cls[C_JI] = 1'b1;
      OPW'(OP_BEX):  begin cls[C_JI] = 1'b1; cls[C_BR] = 1'b1; end
      OPW'(OP_JR):   cls[C_JII] = 1'b1;
      default:       cls[C_UNK] = 1'b1;
    endcase
    // bex is the only branch without an rd compare; it tests r30 instead.
    src[S_RS]  = ~(cls[C_JI] | cls[C_JII]);
    src[S_RT]  = cls[C_R];
    src[S_RD]  = cls[C_ST] | (cls[C_BR] & ~cls[C_JI]) | cls[C_JII];
    src[S_R30] = (opcode == OPW'(OP_BEX));
  end
endmodule

// File: rtl/ins_class_pipe.sv
// rtl/ins_class_pipe.sv - DEPTH-stage instruction class pipe with load-use detect
// Optional per-class retire counters under INS_CLASS_PERF_EN.
module ins_class_pipe
  import ins_class_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int OPW   = 5,
  parameter int REGW  = 5,
  parameter int CNT_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  ins_class_pipe_if.slave   bus
);
  logic [CLS_W-1:0] d_cls;
  logic [SRC_W-1:0] d_src;
  logic [REGW-1:0]  d_rd, d_rs, d_rt;
  logic             unused_ins;

  ins_class_decode #(.OPW(OPW)) u_dec (
    .opcode (bus.in_ins[INS_W-1 -: OPW]),
    .cls    (d_cls),
    .src    (d_src)
  );

  assign d_rd       = bus.in_ins[RD_LSB +: REGW];
  assign d_rs       = bus.in_ins[RS_LSB +: REGW];
  assign d_rt       = bus.in_ins[RT_LSB +: REGW];
  assign unused_ins = ^bus.in_ins[RT_LSB-1:0];

  logic [DEPTH-1:0] v;
  logic [CLS_W-1:0] cls [DEPTH];
  logic [REGW-1:0]  rd  [DEPTH];
  logic [REGW-1:0]  rs0, rt0;
  logic [SRC_W-1:0] src0;

  always_ff @(posedge clock) begin
    if (reset) begin
      v    <= '0;
      rs0  <= '0;
      rt0  <= '0;
      src0 <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        cls[k] <= '0;
        rd[k]  <= '0;
      end
    end else begin
      for (int k = 2; k < DEPTH; k++) begin
        v[k]   <= v[k-1];
        cls[k] <= cls[k-1];
        rd[k]  <= rd[k-1];
      end
      cls[1] <= cls[0];
      rd[1]  <= rd[0];
      if (bus.flush) begin
        v[0] <= 1'b0;
        v[1] <= 1'b0;
      end else if (bus.stall) begin
        v[1] <= 1'b0;
      end else begin
        v[0]   <= bus.in_valid;
        v[1]   <= v[0];
        cls[0] <= d_cls;
        rd[0]  <= d_rd;
        rs0    <= d_rs;
        rt0    <= d_rt;
        src0   <= d_src;
      end
    end
  end

  logic src_hit;

  always_comb begin
    bus.stg_valid = v;
    bus.stg_class = '0;
    bus.stg_rd    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (v[k]) begin
        bus.stg_class[CLS_W*k +: CLS_W] = cls[k];
        bus.stg_rd[REGW*k +: REGW]      = rd[k];
      end
    end
  end

  assign src_hit = (src0[S_RS]  && (rs0   == rd[1])) ||
                   (src0[S_RT]  && (rt0   == rd[1])) ||
                   (src0[S_RD]  && (rd[0] == rd[1])) ||
                   (src0[S_R30] && (rd[1] == REGW'(30)));

  assign bus.load_use = v[0] & v[1] & cls[1][C_LD] & (rd[1] != '0) & src_hit;
  assign bus.any_j_d  = v[0] & (cls[0][C_JI] | cls[0][C_JII]);

`ifdef INS_CLASS_PERF_EN
  logic [CNT_W-1:0] cnt [CLS_W];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int c = 0; c < CLS_W; c++) cnt[c] <= '0;
    end else if (v[DEPTH-1]) begin
      for (int c = 0; c < CLS_W; c++)
        if (cls[DEPTH-1][c]) cnt[c] <= cnt[c] + CNT_W'(1);
    end
  end

  always_comb begin
    bus.ret_cnt = '0;
    for (int c = 0; c < CLS_W; c++) bus.ret_cnt[CNT_W*c +: CNT_W] = cnt[c];
  end
`else
  assign bus.ret_cnt = '0;
`endif
endmodule

// File: tb/tb_ins_class_pipe.sv
// tb/tb_ins_class_pipe.sv - scoreboard bench for ins_class_pipe with directed vectors
module tb_ins_class_pipe;
  import ins_class_pkg::*;

  localparam int DEPTH = 4;
  localparam int REGW  = 5;
  localparam int CNT_W = 4;
  localparam longint unsigned ALL = 64'hFFFF_FFFF_FFFF_FFFF;

  localparam int S_VALID = 0, S_CLS = 1, S_RDK = 2, S_LU = 3, S_AJ = 4, S_RET = 5,
                 S_CLSALL = 6, S_RDALL = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   nvec = 0;
  int   nerr = 0;

  ins_class_pipe_if #(.DEPTH(DEPTH), .REGW(REGW), .CNT_W(CNT_W)) bus ();

  ins_class_pipe #(.DEPTH(DEPTH), .OPW(5), .REGW(REGW), .CNT_W(CNT_W)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int              cyc;
    string           name;
    int              sel;
    int              idx;
    longint unsigned mask;
    longint unsigned exp;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  longint unsigned mon_act;

  function automatic longint unsigned getval(int sel, int idx);
    case (sel)
      S_VALID:  return 64'(bus.stg_valid);
      S_CLS:    return 64'(bus.stg_class[8*idx +: 8]);
      S_RDK:    return 64'(bus.stg_rd[REGW*idx +: REGW]);
      S_LU:     return 64'(bus.load_use);
      S_AJ:     return 64'(bus.any_j_d);
      S_RET:    return 64'(bus.ret_cnt);
      S_CLSALL: return 64'(bus.stg_class);
      S_RDALL:  return 64'(bus.stg_rd);
      default:  return ALL;
    endcase
  endfunction

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      mon_e   = q.pop_front();
      mon_act = getval(mon_e.sel, mon_e.idx) & mon_e.mask;
      nvec++;
      if (mon_e.cyc != cyc || mon_act != mon_e.exp) begin
        nerr++;
        $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d, due %0d)",
                 mon_e.name, mon_act, mon_e.exp, cyc, mon_e.cyc);
      end
    end
  end

  task automatic expect_v(string name, int sel, int idx, longint unsigned mask,
                          longint unsigned exp);
    exp_t e;
    e.cyc = cyc; e.name = name; e.sel = sel; e.idx = idx; e.mask = mask; e.exp = exp;
    q.push_back(e);
  endtask

  task automatic tick(input logic v, input logic [31:0] ins, input logic st, input logic fl);
    bus.in_valid = v;
    bus.in_ins   = ins;
    bus.stall    = st;
    bus.flush    = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) tick(1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] mk(logic [4:0] op, logic [4:0] rd, logic [4:0] rs,
                                     logic [4:0] rt);
    return {op, rd, rs, rt, 12'h000};
  endfunction

  initial begin
    bus.in_valid = 1'b0;
    bus.in_ins   = '0;
    bus.stall    = 1'b0;
    bus.flush    = 1'b0;
    rst = 1'b1;
    idle(2);
    expect_v("reset_valid", S_VALID, 0, ALL, 0);
    expect_v("reset_class", S_CLSALL, 0, ALL, 0);
    expect_v("reset_rd", S_RDALL, 0, ALL, 0);
    expect_v("reset_lu", S_LU, 0, ALL, 0);
    expect_v("reset_aj", S_AJ, 0, ALL, 0);
    expect_v("reset_ret", S_RET, 0, ALL, 0);
    nvec++;
    if (bus.stg_valid !== 4'b0000) begin
      nerr++;
      $display("FAIL direct_reset_valid: got 0x%0h, expected 0x0", bus.stg_valid);
    end
    rst = 1'b0;

    tick(1, mk(OP_ALU, 1, 2, 3), 0, 0);
    expect_v("cls_add", S_CLS, 0, ALL, 8'h01);
    expect_v("v0_add", S_VALID, 0, 1, 1);
    expect_v("aj_add", S_AJ, 0, ALL, 0);
    nvec++;
    if (bus.stg_class[7:0] !== 8'h01) begin
      nerr++;
      $display("FAIL direct_cls_add: got 0x%0h, expected 0x01", bus.stg_class[7:0]);
    end
    tick(1, mk(OP_LW, 3, 2, 0), 0, 0);
    expect_v("cls_lw", S_CLS, 0, ALL, 8'h12);
    tick(1, mk(OP_SW, 4, 1, 3), 0, 0);
    expect_v("cls_sw", S_CLS, 0, ALL, 8'h22);
    expect_v("lu_sw_rt_ignored", S_LU, 0, ALL, 0);
    tick(1, mk(OP_J, 0, 0, 0), 0, 0);
    expect_v("cls_j", S_CLS, 0, ALL, 8'h04);
    expect_v("aj_j", S_AJ, 0, ALL, 1);
    expect_v("cls3_add", S_CLS, 3, ALL, 8'h01);
    expect_v("cls2_lw", S_CLS, 2, ALL, 8'h12);
    expect_v("rd2_lw", S_RDK, 2, ALL, 3);
    tick(1, mk(OP_JR, 5, 0, 0), 0, 0);
    expect_v("cls_jr", S_CLS, 0, ALL, 8'h08);
    expect_v("aj_jr", S_AJ, 0, ALL, 1);
    tick(1, mk(OP_BEX, 0, 0, 0), 0, 0);
    expect_v("cls_bex", S_CLS, 0, ALL, 8'h44);
    tick(1, mk(5'b11111, 0, 0, 0), 0, 0);
    expect_v("cls_unk", S_CLS, 0, ALL, 8'h80);
    expect_v("aj_unk", S_AJ, 0, ALL, 0);
    idle(4);
    expect_v("drained", S_VALID, 0, ALL, 0);

    tick(1, mk(OP_LW, 5, 1, 0), 0, 0);
    tick(1, mk(OP_ALU, 1, 5, 2), 0, 0);
    expect_v("lu_hit", S_LU, 0, ALL, 1);
    expect_v("lu_hit_valid", S_VALID, 0, 3, 3);
    tick(1, mk(OP_J, 0, 0, 0), 1, 0);
    expect_v("stall_valid", S_VALID, 0, ALL, 4'b0101);
    expect_v("stall_lu", S_LU, 0, ALL, 0);
    expect_v("stall_hold_cls0", S_CLS, 0, ALL, 8'h01);
    tick(0, 32'h0, 0, 0);
    expect_v("after_stall_valid", S_VALID, 0, ALL, 4'b1010);
    expect_v("after_stall_cls1", S_CLS, 1, ALL, 8'h01);
    expect_v("after_stall_rd1", S_RDK, 1, ALL, 1);
    idle(4);

    tick(1, mk(OP_LW, 0, 1, 0), 0, 0);
    tick(1, mk(OP_ALU, 1, 0, 0), 0, 0);
    expect_v("lu_r0", S_LU, 0, ALL, 0);
    expect_v("lu_r0_valid", S_VALID, 0, 3, 3);

    tick(1, mk(OP_ADDI, 6, 7, 0), 0, 0);
    expect_v("three_valid", S_VALID, 0, ALL, 4'b0111);
    tick(1, mk(OP_ALU, 2, 2, 2), 1, 1);
    expect_v("flush_s01", S_VALID, 0, 3, 0);
    expect_v("flush_s3_valid", S_VALID, 0, 8, 8);
    expect_v("flush_s3_cls", S_CLS, 3, ALL, 8'h12);
    idle(4);

    for (int i = 0; i < 4; i++) tick(1, mk(OP_ALU, 5'(i + 1), 1, 2), 0, 0);
    expect_v("full_valid", S_VALID, 0, ALL, 4'hF);
    nvec++;
    if (bus.stg_valid !== 4'hF) begin
      nerr++;
      $display("FAIL direct_full_valid: got 0x%0h, expected 0xf", bus.stg_valid);
    end
    rst = 1'b1;
    idle(1);
    expect_v("midreset_valid", S_VALID, 0, ALL, 0);
    expect_v("midreset_class", S_CLSALL, 0, ALL, 0);
    nvec++;
    if (bus.stg_valid !== 4'b0000) begin
      nerr++;
      $display("FAIL direct_midreset_valid: got 0x%0h, expected 0x0", bus.stg_valid);
    end
    rst = 1'b0;

`ifdef INS_CLASS_PERF_EN
    for (int i = 0; i < 17; i++) tick(1, mk(OP_ALU, 1, 2, 3), 0, 0);
    idle(4);
    expect_v("ret_wrap", S_RET, 0, ALL, 64'h1);
`else
    for (int i = 0; i < 6; i++) tick(1, mk(OP_ALU, 1, 2, 3), 0, 0);
    idle(4);
    expect_v("ret_tied", S_RET, 0, ALL, 0);
`endif

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #1;
    while (q.size() > 0) begin
      mon_e = q.pop_front();
      nvec++;
      nerr++;
      $display("FAIL %s: got no sample, expected 0x%0h (timeout)", mon_e.name, mon_e.exp);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
